rsa_decrypt_engine: RTL and testbench



---
 rtl/rsa_pkg.sv | 20 ++
 rtl/rsa_modmul_seq.sv | 60 ++++++
 rtl/rsa_decrypt_engine.sv | 142 ++++++++++++++
 tb/tb_rsa_decrypt_engine.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared constants and types for the RSA decryption engine.
package rsa_pkg;
   localparam int W = 16;
   localparam int RED_CYCLES = 1 + 2*W;
   localparam int IW = $clog2(W);
   localparam int CW = $clog2(2*W);

   typedef logic [W-1:0] word_t;
   typedef logic [2*W-1:0] dword_t;
   typedef logic [IW-1:0] idx_t;
   typedef logic [CW-1:0] cnt_t;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      SQR,
      MUL,
      DONE
   } state_t;
endpackage

// File: rtl/rsa_modmul_seq.sv
// Sequential a*b mod n: one product-load cycle, then one restoring
// quotient bit per cycle, MSB first. done pulses once r is final.
module rsa_modmul_seq
   import rsa_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  start,
   input  word_t a,
   input  word_t b,
   input  word_t n,
   output logic  done,
   output word_t r
);
   dword_t     prod;
   word_t      rem;
   word_t      n_q;
   cnt_t       cnt;
   logic       run;
   logic [W:0] sh;
   word_t      diff;
   logic       ge;

   // rem < n keeps sh < 2n, so the difference always fits in W bits
   always_comb begin
      sh   = {rem, prod[2*W-1]};
      ge   = sh >= {1'b0, n_q};
      diff = sh[W-1:0] - n_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod <= '0;
         rem  <= '0;
         n_q  <= '0;
         cnt  <= '0;
         run  <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            prod <= dword_t'(a) * dword_t'(b);
            rem  <= '0;
            n_q  <= n;
            cnt  <= '0;
            run  <= 1'b1;
         end else if (run) begin
            prod <= prod << 1;
            rem  <= ge ? diff : sh[W-1:0];
            cnt  <= cnt + cnt_t'(1);
            if (cnt == cnt_t'(RED_CYCLES - 2)) begin
               run  <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign r = rem;
endmodule

// File: rtl/rsa_decrypt_engine.sv
// RSA decryption core: plain = cipher^d mod n, left-to-right
// square-and-multiply over a shared sequential modular multiplier.
module rsa_decrypt_engine
   import rsa_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  in_valid,
   output logic  in_ready,
   input  word_t cipher,
   input  word_t priv_d,
   input  word_t mod_n,
   output logic  out_valid,
   input  logic  out_ready,
   output word_t plain,
   output logic  err,
   output logic  busy
);
   state_t state, state_nx;
   word_t  acc, acc_nx;
   word_t  base, base_nx;
   word_t  d_q, d_nx;
   word_t  n_q, n_nx;
   idx_t   idx, idx_nx;
   logic   err_q, err_nx;

   logic   mm_start;
   word_t  mm_a, mm_b, mm_n;
   logic   mm_done;
   word_t  mm_r;

   rsa_modmul_seq u_mm (
      .clk   (clk),
      .rst_n (rst_n),
      .start (mm_start),
      .a     (mm_a),
      .b     (mm_b),
      .n     (mm_n),
      .done  (mm_done),
      .r     (mm_r)
   );

   // Each multiply is kicked on the edge the previous one retires,
   // so operands come from the freshly computed acc_nx.
   always_comb begin
      state_nx = state;
      acc_nx   = acc;
      base_nx  = base;
      d_nx     = d_q;
      n_nx     = n_q;
      idx_nx   = idx;
      err_nx   = err_q;
      mm_start = 1'b0;
      mm_a     = '0;
      mm_b     = '0;
      mm_n     = n_q;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               d_nx   = priv_d;
               n_nx   = mod_n;
               idx_nx = idx_t'(W - 1);
               if (mod_n < word_t'(2)) begin
                  state_nx = DONE;
                  err_nx   = 1'b1;
                  acc_nx   = '0;
               end else begin
                  state_nx = PREP;
                  err_nx   = 1'b0;
                  acc_nx   = word_t'(1);
                  mm_start = 1'b1;
                  mm_a     = cipher;
                  mm_b     = word_t'(1);
                  mm_n     = mod_n;
               end
            end
         end
         PREP: begin
            if (mm_done) begin
               base_nx  = mm_r;
               state_nx = SQR;
               mm_start = 1'b1;
               mm_a     = acc;
               mm_b     = acc;
            end
         end
         SQR: begin
            if (mm_done) begin
               acc_nx   = mm_r;
               state_nx = MUL;
               mm_start = 1'b1;
               mm_a     = mm_r;
               mm_b     = base;
            end
         end
         MUL: begin
            if (mm_done) begin
               if (d_q[idx]) acc_nx = mm_r;
               if (idx == '0) begin
                  state_nx = DONE;
               end else begin
                  idx_nx   = idx - idx_t'(1);
                  state_nx = SQR;
                  mm_start = 1'b1;
                  mm_a     = acc_nx;
                  mm_b     = acc_nx;
               end
            end
         end
         DONE: begin
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         base  <= '0;
         d_q   <= '0;
         n_q   <= '0;
         idx   <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_nx;
         acc   <= acc_nx;
         base  <= base_nx;
         d_q   <= d_nx;
         n_q   <= n_nx;
         idx   <= idx_nx;
         err_q <= err_nx;
      end
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);
   assign plain     = out_valid ? acc : '0;
   assign err       = out_valid & err_q;
endmodule

// File: tb/tb_rsa_decrypt_engine.sv
// Self-checking bench for rsa_decrypt_engine with a result scoreboard.
module tb_rsa_decrypt_engine;
   localparam int LAT = 1089;

   typedef struct packed {
      logic        e;
      logic [15:0] p;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] cipher = '0;
   logic [15:0] priv_d = '0;
   logic [15:0] mod_n = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] plain;
   logic        err;
   logic        busy;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   rsa_decrypt_engine dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .cipher    (cipher),
      .priv_d    (priv_d),
      .mod_n     (mod_n),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .plain     (plain),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] model(input logic [15:0] c,
                                         input logic [15:0] d,
                                         input logic [15:0] n);
      longint nn, r, b;
      nn = longint'(n);
      r  = 1;
      b  = longint'(c) % nn;
      for (int i = 0; i < 16; i++) begin
         if (d[i]) r = (r * b) % nn;
         b = (b * b) % nn;
      end
      return r[15:0];
   endfunction

   task automatic send_job(input logic [15:0] c, input logic [15:0] d,
                           input logic [15:0] n, input exp_t e);
      int w;
      w = 0;
      while (!in_ready && w < 100) begin
         @(posedge clk); #1; w++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL send_ready in_ready=%0b required 1", in_ready);
      end
      cipher   = c;
      priv_d   = d;
      mod_n    = n;
      in_valid = 1'b1;
      sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      cipher   = 16'($urandom);
      priv_d   = 16'($urandom);
      mod_n    = 16'($urandom);
   endtask

   task automatic wait_out(input int exp_lat, input string tag);
      int   lat;
      exp_t e;
      lat = 0;
      while (!out_valid && lat < LAT + 50) begin
         @(posedge clk); #1; lat++;
      end
      checks++;
      if (lat != exp_lat) begin
         errors++;
         $display("FAIL %s_latency got %0d required %0d", tag, lat, exp_lat);
      end
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s_scoreboard empty got 0 required 1", tag);
         return;
      end
      e = sb.pop_front();
      checks++;
      if (plain !== e.p || err !== e.e) begin
         errors++;
         $display("FAIL %s_result plain=%0d err=%0b required plain=%0d err=%0b",
                  tag, plain, err, e.p, e.e);
      end
   endtask

   task automatic take_out(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_release in_ready=%0b out_valid=%0b required 1 0",
                  tag, in_ready, out_valid);
      end
   endtask

   task automatic test_reset();
      in_valid = 1'b1;
      mod_n    = 16'd3233;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || plain !== 16'd0 ||
          err !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset rdy=%0b ov=%0b plain=%0d err=%0b busy=%0b required 1 0 0 0 0",
                  in_ready, out_valid, plain, err, busy);
      end
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_textbook();
      send_job(16'd2790, 16'd2753, 16'd3233, '{e: 1'b0, p: 16'd65});
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL textbook_busy busy=%0b in_ready=%0b required 1 0",
                  busy, in_ready);
      end
      wait_out(LAT, "textbook");
      take_out("textbook");
   endtask

   task automatic test_small_key();
      send_job(16'd31, 16'd7, 16'd33, '{e: 1'b0, p: 16'd4});
      wait_out(LAT, "small");
      take_out("small");
      send_job(16'd31, 16'd0, 16'd33, '{e: 1'b0, p: 16'd1});
      wait_out(LAT, "d_zero");
      take_out("d_zero");
      send_job(16'd0, 16'd7, 16'd33, '{e: 1'b0, p: 16'd0});
      wait_out(LAT, "c_zero");
      take_out("c_zero");
   endtask

   task automatic test_cipher_ge_n();
      send_job(16'd3300, 16'd1, 16'd3233, '{e: 1'b0, p: 16'd67});
      wait_out(LAT, "c_ge_n");
      take_out("c_ge_n");
   endtask

   task automatic test_err();
      send_job(16'd1234, 16'd77, 16'd1, '{e: 1'b1, p: 16'd0});
      wait_out(0, "mod_one");
      take_out("mod_one");
      send_job(16'd55, 16'd3, 16'd0, '{e: 1'b1, p: 16'd0});
      wait_out(0, "mod_zero");
      take_out("mod_zero");
   endtask

   task automatic test_backpressure();
      logic [15:0] p0;
      logic        e0;
      int          bad;
      out_ready = 1'b0;
      send_job(16'd31, 16'd7, 16'd33, '{e: 1'b0, p: 16'd4});
      wait_out(LAT, "bp");
      p0  = plain;
      e0  = err;
      bad = 0;
      repeat (50) begin
         @(posedge clk); #1;
         if (plain !== p0 || err !== e0 || out_valid !== 1'b1 ||
             in_ready !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL bp_hold unstable_cycles=%0d required 0", bad);
      end
      take_out("bp");
   endtask

   task automatic test_busy_pulse();
      int extra;
      send_job(16'd2790, 16'd2753, 16'd3233, '{e: 1'b0, p: 16'd65});
      repeat (100) @(posedge clk);
      #1;
      cipher   = 16'd31;
      priv_d   = 16'd7;
      mod_n    = 16'd33;
      in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_pulse in_ready=%0b busy=%0b required 0 1",
                  in_ready, busy);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_out(LAT - 101, "busy_job");
      take_out("busy_job");
      extra = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (out_valid || busy) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL busy_second_job active_cycles=%0d required 0", extra);
      end
   endtask

   task automatic test_reset_mid_job();
      send_job(16'd2790, 16'd2753, 16'd3233, '{e: 1'b0, p: 16'd65});
      repeat (499) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || plain !== 16'd0 ||
          err !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset rdy=%0b ov=%0b plain=%0d err=%0b busy=%0b required 1 0 0 0 0",
                  in_ready, out_valid, plain, err, busy);
      end
      void'(sb.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_job(16'd2790, 16'd2753, 16'd3233, '{e: 1'b0, p: 16'd65});
      wait_out(LAT, "after_reset");
      take_out("after_reset");
   endtask

   task automatic test_random();
      logic [15:0] c, d, n;
      for (int k = 0; k < 3; k++) begin
         c = 16'($urandom);
         d = 16'($urandom);
         n = 16'($urandom_range(2, 65535));
         send_job(c, d, n, '{e: 1'b0, p: model(c, d, n)});
         wait_out(LAT, "random");
         take_out("random");
      end
   endtask

   initial begin
      test_reset();
      test_textbook();
      test_small_key();
      test_cipher_ge_n();
      test_err();
      test_backpressure();
      test_busy_pulse();
      test_reset_mid_job();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
